instruction_fetch: RTL and testbench

Fetch stage of the VeSPA CPU pipeline, directly upstream of instruction decode. Owns the program counter, issues one-at-a-time requests to instruction memory over a req/ack handshake, and presents a registered 32-bit instruction word plus its PC to decode. Honours hazard-unit stalls through a one-entry hold buffer and handles branch/jump redirects from execute, including discarding a stale in-flight fetch.

---
 rtl/instruction_fetch_pkg.sv | 11 +
 rtl/instruction_fetch.sv | 82 ++++++++
 tb/tb_instruction_fetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: bus width, reset/NOP constants and fetch-state encodings
package instruction_fetch_pkg;
  localparam int BUS_MSB = 31;
  localparam logic [BUS_MSB:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [BUS_MSB:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DROP  = 2'b10
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, imem req/ack fetch, stall hold buffer and redirect with stale-fetch drop
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [BUS_MSB:0] RESET_VECTOR = RESET_PC_DEFAULT
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Stall,
  input  logic             i_Redirect,
  input  logic [BUS_MSB:0] i_RedirectPc,
  output logic             o_IMemReq,
  output logic [BUS_MSB:0] o_IMemAddr,
  input  logic             i_IMemAck,
  input  logic [BUS_MSB:0] i_IMemData,
  output logic [BUS_MSB:0] o_InstructionRegister,
  output logic [BUS_MSB:0] o_IrPc,
  output logic [BUS_MSB:0] o_IrPcPlus4,
  output logic             o_IrValid
);
  fetch_state_t r_State;
  logic [BUS_MSB:0] r_Pc, r_ReqAddr, r_Ir, r_IrPc, r_BufData, r_BufPc;
  logic r_IrValid;
  logic [BUS_MSB:0] w_Target, w_PcPlus4;
  logic w_RedirToDrop;
  assign w_Target = i_RedirectPc & ~32'd3;
  assign w_PcPlus4 = r_Pc + 32'd4;
  // An unacked request cannot be withdrawn, so a redirect must wait out its ack in DROP
  assign w_RedirToDrop = (r_State == DROP) || (r_State == FETCH && !i_IMemAck);
  assign o_IMemReq = r_State != HOLD;
  assign o_IMemAddr = r_State == DROP ? r_ReqAddr : r_Pc;
  assign o_InstructionRegister = r_Ir;
  assign o_IrPc = r_IrPc;
  assign o_IrPcPlus4 = r_IrPc + 32'd4;
  assign o_IrValid = r_IrValid;
  // Fetch FSM: redirect beats stall, stall beats normal fetch; r_ReqAddr freezes only in DROP
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State   <= FETCH;
      r_Pc      <= RESET_VECTOR;
      r_ReqAddr <= RESET_VECTOR;
      r_Ir      <= NOP_INSTR;
      r_IrPc    <= '0;
      r_IrValid <= 1'b0;
      r_BufData <= '0;
      r_BufPc   <= '0;
    end else if (i_Redirect) begin
      r_Ir      <= NOP_INSTR;
      r_IrValid <= 1'b0;
      r_Pc      <= w_Target;
      r_State   <= w_RedirToDrop ? DROP : FETCH;
      r_ReqAddr <= w_RedirToDrop ? r_ReqAddr : w_Target;
    end else begin
      case (r_State)
        FETCH: if (i_IMemAck) begin
          r_Pc      <= w_PcPlus4;
          r_ReqAddr <= w_PcPlus4;
          if (i_Stall) begin
            r_BufData <= i_IMemData;
            r_BufPc   <= r_Pc;
            r_State   <= HOLD;
          end else begin
            r_Ir      <= i_IMemData;
            r_IrPc    <= r_Pc;
            r_IrValid <= 1'b1;
          end
        end
        HOLD: if (!i_Stall) begin
          r_Ir      <= r_BufData;
          r_IrPc    <= r_BufPc;
          r_IrValid <= 1'b1;
          r_State   <= FETCH;
        end
        DROP: if (i_IMemAck) begin
          r_ReqAddr <= r_Pc;
          r_State   <= FETCH;
        end
        default: r_State <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch, stall hold, redirect/drop, PC wrap and async reset
module tb_instruction_fetch;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redir = 1'b0, ack_en = 1'b0;
  logic [31:0] redir_pc = '0;
  logic req, ack, valid;
  logic [31:0] addr, data, ir, ir_pc, ir_pc4;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign ack = req & ack_en;
  assign data = addr;
  instruction_fetch dut (
    .i_Clk(clk), .i_Rst(rst), .i_Stall(stall), .i_Redirect(redir), .i_RedirectPc(redir_pc),
    .o_IMemReq(req), .o_IMemAddr(addr), .i_IMemAck(ack), .i_IMemData(data),
    .o_InstructionRegister(ir), .o_IrPc(ir_pc), .o_IrPcPlus4(ir_pc4), .o_IrValid(valid)
  );
  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir got=%h exp=%h", ir, 32'h0); end checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid); end checks++;
    if (ir_pc !== 32'h0) begin errors++; $display("FAIL rst_irpc got=%h exp=0", ir_pc); end checks++;
    rst = 1'b0; ack_en = 1'b1; #1;
    if (req !== 1'b1 || addr !== 32'h0) begin errors++; $display("FAIL rst_req got=%b/%h exp=1/0", req, addr); end checks++;
  endtask
  task automatic test_stream();
    @(negedge clk);
    if (ir !== 32'h0 || valid !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL stream0 got ir=%h v=%b a=%h exp 0/1/4", ir, valid, addr); end checks++;
    @(negedge clk);
    if (ir !== 32'h4 || ir_pc !== 32'h4 || ir_pc4 !== 32'h8) begin errors++; $display("FAIL stream1 got ir=%h pc=%h pc4=%h exp 4/4/8", ir, ir_pc, ir_pc4); end checks++;
    @(negedge clk);
    if (ir !== 32'h8 || addr !== 32'hC) begin errors++; $display("FAIL stream2 got ir=%h a=%h exp 8/c", ir, addr); end checks++;
  endtask
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ir !== 32'h8 || req !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got ir=%h req=%b exp 8/0", i, ir, req); end checks++;
    end
    stall = 1'b0;
    @(negedge clk);
    if (ir !== 32'hC || ir_pc !== 32'hC || valid !== 1'b1) begin errors++; $display("FAIL stall_release got ir=%h pc=%h v=%b exp c/c/1", ir, ir_pc, valid); end checks++;
    if (req !== 1'b1 || addr !== 32'h10) begin errors++; $display("FAIL stall_nextreq got=%b/%h exp 1/10", req, addr); end checks++;
  endtask
  task automatic test_redirect_drop();
    ack_en = 1'b0;
    @(negedge clk);
    if (req !== 1'b1 || addr !== 32'h10 || ir !== 32'hC) begin errors++; $display("FAIL drop_wait got req=%b a=%h ir=%h exp 1/10/c", req, addr, ir); end checks++;
    redir = 1'b1; redir_pc = 32'h103;
    @(negedge clk);
    redir = 1'b0;
    if (ir !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL drop_bubble got ir=%h v=%b exp 0/0", ir, valid); end checks++;
    if (req !== 1'b1 || addr !== 32'h10) begin errors++; $display("FAIL drop_stale got req=%b a=%h exp 1/10", req, addr); end checks++;
    ack_en = 1'b1;
    @(negedge clk);
    if (ir !== 32'h0 || valid !== 1'b0 || addr !== 32'h100) begin errors++; $display("FAIL drop_discard got ir=%h v=%b a=%h exp 0/0/100", ir, valid, addr); end checks++;
    @(negedge clk);
    if (ir !== 32'h100 || valid !== 1'b1) begin errors++; $display("FAIL drop_target got ir=%h v=%b exp 100/1", ir, valid); end checks++;
  endtask
  task automatic test_redirect_stall();
    stall = 1'b1;
    @(negedge clk);
    if (req !== 1'b0 || ir !== 32'h100) begin errors++; $display("FAIL rs_hold got req=%b ir=%h exp 0/100", req, ir); end checks++;
    redir = 1'b1; redir_pc = 32'h200;
    @(negedge clk);
    redir = 1'b0; stall = 1'b0;
    if (ir !== 32'h0 || valid !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL rs_bubble got ir=%h v=%b req=%b a=%h exp 0/0/1/200", ir, valid, req, addr); end checks++;
    @(negedge clk);
    if (ir !== 32'h200 || ir_pc !== 32'h200 || valid !== 1'b1) begin errors++; $display("FAIL rs_resume got ir=%h pc=%h v=%b exp 200/200/1", ir, ir_pc, valid); end checks++;
  endtask
  task automatic test_wrap();
    redir = 1'b1; redir_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redir = 1'b0;
    if (valid !== 1'b0 || addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect got v=%b a=%h exp 0/fffffffc", valid, addr); end checks++;
    @(negedge clk);
    if (ir_pc !== 32'hFFFF_FFFC || ir_pc4 !== 32'h0 || addr !== 32'h0) begin errors++; $display("FAIL wrap got pc=%h pc4=%h a=%h exp fffffffc/0/0", ir_pc, ir_pc4, addr); end checks++;
    @(negedge clk);
    if (ir !== 32'h0 || valid !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL wrap_next got ir=%h v=%b a=%h exp 0/1/4", ir, valid, addr); end checks++;
  endtask
  task automatic test_async_reset();
    ack_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1; ack_en = 1'b1; #1;
    if (valid !== 1'b0 || addr !== 32'h0 || ir !== 32'h0) begin errors++; $display("FAIL async_rst got v=%b a=%h ir=%h exp 0/0/0", valid, addr, ir); end checks++;
    @(posedge clk); #1;
    if (valid !== 1'b0 || addr !== 32'h0) begin errors++; $display("FAIL rst_ack_ignored got v=%b a=%h exp 0/0", valid, addr); end checks++;
    ack_en = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL async_release got req=%b a=%h v=%b exp 1/0/0", req, addr, valid); end checks++;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
